// File: rtl/modexp_sequencer.sv
// modexp_sequencer
// Host-side front end for the 4096-bit ModExp core. Operand words are buffered
// from a valid/ready stream, replayed to ModExp back-to-back after a startInput
// pulse, then startCompute is held until ModExp reports DONE_STATE. The result
// words are captured under getResult and drained to the host on a second
// valid/ready stream.
//
// Ports
//   clk, reset            single clock; asynchronous active-high reset
//   in_data/in_valid/in_ready     host operand stream (accepted in LOAD only)
//   out_data/out_valid/out_ready  host result stream (offered in DRAIN only)
//   busy                  FSM is not in IDLE
//   done                  one-cycle pulse in the cycle after the final out handshake
//   err                   sticky COMPUTE timeout; cleared when the next word 0 is accepted
//   startInput, startCompute, getResult, inp   controls and data to ModExp
//   outp, stateModExp     result data and state from ModExp
//
// GAP_CYCLES must be at least 1.
//
// state   | meaning
// IDLE    | one-cycle pause after reset, drain completion or timeout
// LOAD    | accept NUM_WORDS host words into ibuf
// START   | startInput pulse
// FEED    | replay ibuf on inp, one word per cycle, no stalls
// GAP     | all ModExp controls low for GAP_CYCLES cycles
// COMPUTE | startCompute high, waiting for DONE_STATE or timeout
// FETCH   | getResult high, capture NUM_WORDS outp words into obuf
// DRAIN   | offer obuf to the host
module modexp_sequencer #(
  parameter int         DATA_WIDTH = 128,
  parameter int         NUM_WORDS  = 32,
  parameter int         GAP_CYCLES = 2,
  parameter logic [4:0] DONE_STATE = 5'd31,
  parameter int         RESULT_LAT = 1,
  parameter int         TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  startInput,
  output logic                  startCompute,
  output logic                  getResult,
  output logic [DATA_WIDTH-1:0] inp,
  input  logic [DATA_WIDTH-1:0] outp,
  input  logic [4:0]            stateModExp
);

  localparam int CW = $clog2(NUM_WORDS) + 1;
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int LW = (RESULT_LAT > 0) ? $clog2(RESULT_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, FEED, GAP, COMPUTE, FETCH, DRAIN} stateT;

  stateT                 state;
  logic [CW-1:0]         wcnt;
  logic [CW-1:0]         rcnt;
  logic [GW-1:0]         gapCnt;
  logic [LW-1:0]         latCnt;
  logic [31:0]           tmoCnt;
  logic [DATA_WIDTH-1:0] ibuf [NUM_WORDS];
  logic [DATA_WIDTH-1:0] obuf [NUM_WORDS];

  assign busy = (state != IDLE);

  // Buffers carry no reset; their contents are only read after being written.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready)
      ibuf[wcnt[IW-1:0]] <= in_data;
    if (state == FETCH && latCnt == '0)
      obuf[rcnt[IW-1:0]] <= outp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      rcnt         <= '0;
      gapCnt       <= '0;
      latCnt       <= '0;
      tmoCnt       <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      startInput   <= 1'b0;
      startCompute <= 1'b0;
      getResult    <= 1'b0;
      inp          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          wcnt     <= '0;
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            if (wcnt == '0)
              err <= 1'b0;
            if (wcnt == LAST) begin
              state      <= START;
              in_ready   <= 1'b0;
              startInput <= 1'b1;
              wcnt       <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        START: begin
          // inp is registered, so the first word is loaded here to appear
          // in the cycle right after the startInput pulse.
          startInput <= 1'b0;
          inp        <= ibuf[IW'(0)];
          wcnt       <= '0;
          state      <= FEED;
        end
        FEED: begin
          if (wcnt == LAST) begin
            inp    <= '0;
            wcnt   <= '0;
            gapCnt <= GW'(GAP_CYCLES - 1);
            state  <= GAP;
          end else begin
            inp  <= ibuf[wcnt[IW-1:0] + IW'(1)];
            wcnt <= wcnt + 1'b1;
          end
        end
        GAP: begin
          if (gapCnt == '0) begin
            startCompute <= 1'b1;
            tmoCnt       <= 32'(TIMEOUT - 1);
            state        <= COMPUTE;
          end else begin
            gapCnt <= gapCnt - 1'b1;
          end
        end
        COMPUTE: begin
          // Completion wins over a timeout landing in the same cycle.
          if (stateModExp == DONE_STATE) begin
            getResult <= 1'b1;
            latCnt    <= LW'(RESULT_LAT);
            rcnt      <= '0;
            state     <= FETCH;
          end else if (TIMEOUT != 0 && tmoCnt == '0) begin
            err          <= 1'b1;
            startCompute <= 1'b0;
            state        <= IDLE;
          end else begin
            tmoCnt <= tmoCnt - 1'b1;
          end
        end
        FETCH: begin
          if (latCnt != '0) begin
            latCnt <= latCnt - 1'b1;
          end else if (rcnt == LAST) begin
            getResult    <= 1'b0;
            startCompute <= 1'b0;
            out_valid    <= 1'b1;
            out_data     <= (NUM_WORDS == 1) ? outp : obuf[IW'(0)];
            rcnt         <= '0;
            state        <= DRAIN;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (rcnt == LAST) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              done      <= 1'b1;
              rcnt      <= '0;
              state     <= IDLE;
            end else begin
              out_data <= obuf[rcnt[IW-1:0] + IW'(1)];
              rcnt     <= rcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
module tb_modexp_sequencer;
  localparam int DW = 128;
  localparam int NW = 32;
  localparam int GAP = 2;
  localparam int TMO = 50;
  localparam longint unsigned RSA_N = 3233;
  localparam longint unsigned RSA_E = 17;
  localparam longint unsigned RSA_D = 2753;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] outp = '0;
  logic [4:0]    stateModExp = '0;

  logic          in_ready, out_valid, busy, done, err, startInput, startCompute, getResult;
  logic [DW-1:0] out_data, inp;
  logic          in_readyT, out_validT, busyT, doneT, errT, startInputT, startComputeT, getResultT;
  logic [DW-1:0] out_dataT, inpT;

  int checks = 0;
  int fails = 0;
  logic [DW-1:0] words [NW];
  logic [DW-1:0] expOut [$];

  modexp_sequencer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .err(err), .startInput(startInput), .startCompute(startCompute), .getResult(getResult),
    .inp(inp), .outp(outp), .stateModExp(stateModExp)
  );

  modexp_sequencer #(.TIMEOUT(TMO)) dutTo (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_readyT),
    .out_data(out_dataT), .out_valid(out_validT), .out_ready(out_ready), .busy(busyT), .done(doneT),
    .err(errT), .startInput(startInputT), .startCompute(startComputeT), .getResult(getResultT),
    .inp(inpT), .outp(outp), .stateModExp(stateModExp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned modpow(longint unsigned b, longint unsigned e, longint unsigned m);
    longint unsigned r = 1;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [4:0] notDone();
    return 5'($urandom_range(0, 30));
  endfunction

  // Pushes words[] into the host stream with random idle gaps. Returns in the
  // cycle after the last handshake.
  task automatic loadWords();
    int g;
    int w;
    for (int i = 0; i < NW; i++) begin
      g = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (g) tick();
      in_data = words[i];
      in_valid = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        $display("FAIL load_ready word %0d: in_ready=%b, expected 1", i, in_ready);
        fails++;
      end
      tick();
    end
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic releaseReset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    outp = '0;
    stateModExp = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, busy, done, err, startInput, startCompute, getResult} !== 8'b0) begin
      $display("FAIL reset_ctrl: got %b, expected 00000000",
               {in_ready, out_valid, busy, done, err, startInput, startCompute, getResult});
      fails++;
    end
    checks++;
    if (inp !== '0 || out_data !== '0) begin
      $display("FAIL reset_data: inp=%h out_data=%h, expected 0", inp, out_data);
      fails++;
    end
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_idle: in_ready=%b busy=%b, expected 0 0", in_ready, busy);
      fails++;
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL reset_load: in_ready=%b busy=%b, expected 1 1", in_ready, busy);
      fails++;
    end
  endtask

  // Expected ModExp-side waveform relative to the startInput cycle j=0.
  task automatic test_feed();
    logic [DW-1:0] expInp;
    for (int i = 0; i < NW; i++) words[i] = DW'(i);
    loadWords();
    for (int j = 0; j <= NW + GAP + 6; j++) begin
      expInp = (j >= 1 && j <= NW) ? words[j-1] : '0;
      checks++;
      if (startInput !== (j == 0)) begin
        $display("FAIL feed_startInput j=%0d: got %b, expected %b", j, startInput, (j == 0));
        fails++;
      end
      checks++;
      if (inp !== expInp) begin
        $display("FAIL feed_inp j=%0d: got %h, expected %h", j, inp, expInp);
        fails++;
      end
      checks++;
      if (startCompute !== (j >= NW + 1 + GAP)) begin
        $display("FAIL feed_startCompute j=%0d: got %b, expected %b", j, startCompute, (j >= NW + 1 + GAP));
        fails++;
      end
      tick();
    end
  endtask

  task automatic test_compute_fetch();
    for (int c = 0; c < 100; c++) begin
      stateModExp = notDone();
      checks++;
      if ({getResult, startCompute} !== 2'b01) begin
        $display("FAIL compute_hold c=%0d: getResult,startCompute=%b, expected 01", c, {getResult, startCompute});
        fails++;
      end
      tick();
    end
    stateModExp = 5'd31;
    tick();
    stateModExp = '0;
    expOut.delete();
    for (int c = 0; c <= NW; c++) begin
      outp = (c >= 1) ? DW'(8'hA0 + c - 1) : {$urandom, $urandom, $urandom, $urandom};
      if (c >= 1) expOut.push_back(DW'(8'hA0 + c - 1));
      checks++;
      if ({getResult, startCompute} !== 2'b11) begin
        $display("FAIL fetch_ctrl c=%0d: getResult,startCompute=%b, expected 11", c, {getResult, startCompute});
        fails++;
      end
      tick();
    end
    outp = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if ({getResult, startCompute, out_valid} !== 3'b001) begin
      $display("FAIL fetch_exit: getResult,startCompute,out_valid=%b, expected 001",
               {getResult, startCompute, out_valid});
      fails++;
    end
  endtask

  task automatic test_drain_backpressure();
    int idx = 0;
    int cyc = 0;
    while (idx < NW && cyc < 600) begin
      out_ready = ($urandom_range(0, 2) != 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== expOut[idx]) begin
        $display("FAIL drain_word %0d: valid=%b data=%h, expected 1 %h", idx, out_valid, out_data, expOut[idx]);
        fails++;
      end
      checks++;
      if (done !== 1'b0) begin
        $display("FAIL drain_done_early %0d: done=%b, expected 0", idx, done);
        fails++;
      end
      if (out_valid === 1'b1 && out_ready) idx++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (idx != NW) begin
      $display("FAIL drain_timeout: drained %0d words, expected %0d", idx, NW);
      fails++;
    end
    checks++;
    if ({done, out_valid, busy} !== 3'b100) begin
      $display("FAIL drain_end: done,out_valid,busy=%b, expected 100", {done, out_valid, busy});
      fails++;
    end
    tick();
    checks++;
    if ({done, in_ready} !== 2'b01) begin
      $display("FAIL back_to_back: done,in_ready=%b, expected 01", {done, in_ready});
      fails++;
    end
  endtask

  task automatic test_reset_mid_feed();
    for (int i = 0; i < NW; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
    loadWords();
    repeat (11) tick();
    checks++;
    if (inp !== words[10]) begin
      $display("FAIL midfeed_word10: inp=%h, expected %h", inp, words[10]);
      fails++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, done, err, startInput, startCompute, getResult} !== 8'b0 || inp !== '0) begin
      $display("FAIL midfeed_async: ctrl=%b inp=%h, expected 0 0",
               {in_ready, out_valid, busy, done, err, startInput, startCompute, getResult}, inp);
      fails++;
    end
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL midfeed_idle: in_ready=%b, expected 0", in_ready);
      fails++;
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL midfeed_load: in_ready=%b, expected 1", in_ready);
      fails++;
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NW; i++) words[i] = DW'($urandom);
    stateModExp = '0;
    loadWords();
    checks++;
    if (startInputT !== 1'b1) begin
      $display("FAIL tmo_start: startInput=%b, expected 1", startInputT);
      fails++;
    end
    repeat (NW + 1 + GAP) tick();
    for (int k = 0; k < TMO; k++) begin
      checks++;
      if ({errT, startComputeT} !== 2'b01) begin
        $display("FAIL tmo_compute k=%0d: err,startCompute=%b, expected 01", k, {errT, startComputeT});
        fails++;
      end
      tick();
    end
    checks++;
    if ({errT, startComputeT, getResultT, busyT} !== 4'b1000) begin
      $display("FAIL tmo_fire: err,startCompute,getResult,busy=%b, expected 1000",
               {errT, startComputeT, getResultT, busyT});
      fails++;
    end
    checks++;
    if (startCompute !== 1'b1) begin
      $display("FAIL tmo_disabled: startCompute=%b, expected 1", startCompute);
      fails++;
    end
    tick();
    tick();
    checks++;
    if ({errT, in_readyT} !== 2'b11) begin
      $display("FAIL tmo_reload: err,in_ready=%b, expected 11", {errT, in_readyT});
      fails++;
    end
    in_data = DW'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (errT !== 1'b0) begin
      $display("FAIL tmo_clear: err=%b, expected 0", errT);
      fails++;
    end
  endtask

  // ModExp stand-in decrypts whatever it sees on inp; the expected result is
  // the original plaintext chosen before encryption.
  task automatic test_rsa();
    longint unsigned msg [NW];
    longint unsigned cap [NW];
    int w;
    releaseReset();
    for (int i = 0; i < NW; i++) begin
      msg[i] = longint'($urandom_range(2, 3232));
      words[i] = DW'(modpow(msg[i], RSA_E, RSA_N));
    end
    loadWords();
    tick();
    for (int k = 0; k < NW; k++) begin
      cap[k] = longint'(inp[63:0]);
      tick();
    end
    w = 0;
    while (startCompute !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    checks++;
    if (startCompute !== 1'b1) begin
      $display("FAIL rsa_startCompute: got %b, expected 1", startCompute);
      fails++;
    end
    repeat ($urandom_range(5, 40)) begin
      stateModExp = notDone();
      tick();
    end
    stateModExp = 5'd31;
    tick();
    stateModExp = '0;
    for (int c = 0; c <= NW; c++) begin
      outp = (c >= 1) ? DW'(modpow(cap[c-1], RSA_D, RSA_N)) : '1;
      tick();
    end
    outp = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(msg[i])) begin
        $display("FAIL rsa_plain %0d: valid=%b data=%h, expected 1 %h", i, out_valid, out_data, DW'(msg[i]));
        fails++;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      $display("FAIL rsa_done: done=%b, expected 1", done);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_feed();
    test_compute_fetch();
    test_drain_backpressure();
    test_reset_mid_feed();
    test_timeout();
    test_rsa();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
